// File: rtl/reorder_buffer_if.sv
// Handshake bundle between dispatch, writeback, retire and the reorder buffer.
// The master side is the core pipeline; the slave side is the reorder buffer itself.
interface reorder_buffer_if #(
  parameter int TAG_W = 3,
  parameter int XLEN  = 32
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_regwrite;
  logic [XLEN-1:0]  alloc_pc;
  logic [TAG_W-1:0] alloc_tag;
  logic             ROB_full;
  logic             rob_empty;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0]  wb_value;
  logic             wb_mispredict;
  logic [XLEN-1:0]  wb_target;

  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic [4:0]       commit_rd;
  logic             commit_regwrite;
  logic [XLEN-1:0]  commit_value;
  logic [XLEN-1:0]  commit_pc;
  logic             MisPredict;
  logic [XLEN-1:0]  redirect_pc;

  modport master (
    output alloc_valid, alloc_rd, alloc_regwrite, alloc_pc,
    output wb_valid, wb_tag, wb_value, wb_mispredict, wb_target,
    input  alloc_tag, ROB_full, rob_empty,
    input  commit_valid, commit_tag, commit_rd, commit_regwrite,
    input  commit_value, commit_pc, MisPredict, redirect_pc
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_regwrite, alloc_pc,
    input  wb_valid, wb_tag, wb_value, wb_mispredict, wb_target,
    output alloc_tag, ROB_full, rob_empty,
    output commit_valid, commit_tag, commit_rd, commit_regwrite,
    output commit_value, commit_pc, MisPredict, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, completes out of order,
// retires one entry per cycle at head and flushes everything on a mispredicted retire.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  reorder_buffer_if.slave rob
);
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]   head_r;
  logic [TAG_W:0]   tail_r;
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] done_r;
  logic [DEPTH-1:0] mispred_r;

  logic [4:0]       rd_r       [DEPTH];
  logic             regwrite_r [DEPTH];
  logic [XLEN-1:0]  pc_r       [DEPTH];
  logic [XLEN-1:0]  value_r    [DEPTH];
  logic [XLEN-1:0]  target_r   [DEPTH];

  logic [TAG_W:0]   count_s;
  logic [TAG_W-1:0] head_idx_s;
  logic [TAG_W-1:0] tail_idx_s;
  logic             full_s;
  logic             empty_s;
  logic             alloc_fire_s;
  logic             wb_hit_s;
  logic             commit_s;
  logic             flush_s;

  assign count_s      = tail_r - head_r;
  assign head_idx_s   = head_r[TAG_W-1:0];
  assign tail_idx_s   = tail_r[TAG_W-1:0];
  assign full_s       = (count_s == DEPTH_C);
  assign empty_s      = (count_s == {(TAG_W+1){1'b0}});
  assign alloc_fire_s = rob.alloc_valid & ~full_s;
  assign wb_hit_s     = rob.wb_valid & valid_r[rob.wb_tag];
  assign commit_s     = valid_r[head_idx_s] & done_r[head_idx_s];
  assign flush_s      = commit_s & mispred_r[head_idx_s];

  assign rob.alloc_tag = tail_idx_s;
  assign rob.ROB_full  = full_s;
  assign rob.rob_empty = empty_s;

  // Pointer and per-entry status bits; a mispredicted retire wipes the whole buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_s) begin
      head_r    <= '0;
      tail_r    <= '0;
      valid_r   <= '0;
      done_r    <= '0;
      mispred_r <= '0;
    end else begin
      if (alloc_fire_s) begin
        valid_r[tail_idx_s]   <= 1'b1;
        done_r[tail_idx_s]    <= 1'b0;
        mispred_r[tail_idx_s] <= 1'b0;
        tail_r                <= tail_r + {{TAG_W{1'b0}}, 1'b1};
      end
      if (wb_hit_s) begin
        done_r[rob.wb_tag]    <= 1'b1;
        mispred_r[rob.wb_tag] <= rob.wb_mispredict;
      end
      if (commit_s) begin
        valid_r[head_idx_s] <= 1'b0;
        head_r              <= head_r + {{TAG_W{1'b0}}, 1'b1};
      end
    end
  end

  // Payload storage; only read back while the matching valid/done bits are set.
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      rd_r[tail_idx_s]       <= rob.alloc_rd;
      regwrite_r[tail_idx_s] <= rob.alloc_regwrite;
      pc_r[tail_idx_s]       <= rob.alloc_pc;
    end
    if (wb_hit_s) begin
      value_r[rob.wb_tag]  <= rob.wb_value;
      target_r[rob.wb_tag] <= rob.wb_target;
    end
  end

  // Retire port shows the head entry only when it is complete, zeros otherwise.
  always_comb begin
    if (commit_s) begin
      rob.commit_valid    = 1'b1;
      rob.commit_tag      = head_idx_s;
      rob.commit_rd       = rd_r[head_idx_s];
      rob.commit_regwrite = regwrite_r[head_idx_s];
      rob.commit_value    = value_r[head_idx_s];
      rob.commit_pc       = pc_r[head_idx_s];
      rob.MisPredict      = mispred_r[head_idx_s];
      rob.redirect_pc     = mispred_r[head_idx_s] ? target_r[head_idx_s] : {XLEN{1'b0}};
    end else begin
      rob.commit_valid    = 1'b0;
      rob.commit_tag      = {TAG_W{1'b0}};
      rob.commit_rd       = 5'd0;
      rob.commit_regwrite = 1'b0;
      rob.commit_value    = {XLEN{1'b0}};
      rob.commit_pc       = {XLEN{1'b0}};
      rob.MisPredict      = 1'b0;
      rob.redirect_pc     = {XLEN{1'b0}};
    end
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the out-of-order core.
- Allocates one entry per dispatched instruction and collects results from the ALU, LSQ and branch writeback paths.
- Retires completed entries in program order.
- Drives ROB_full and MisPredict into the hazard unit, which converts them into stall and flush.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2
TAG_W, 3, entry index width; must equal log2(DEPTH)
XLEN, 32, data and PC width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
alloc_valid  input  1  dispatch request; only asserted by the front end when the hazard unit's stall=0
alloc_rd  input  5  destination register
alloc_regwrite  input  1  instruction writes rd
alloc_pc  input  XLEN  instruction PC
alloc_tag  output  TAG_W  entry index the current allocation receives (= tail index)
ROB_full  output  1  no free entry
rob_empty  output  1  no valid entry
wb_valid  input  1  result writeback
wb_tag  input  TAG_W  entry being completed
wb_value  input  XLEN  result value
wb_mispredict  input  1  branch resolved mispredicted
wb_target  input  XLEN  correct branch target
commit_valid  output  1  head entry retires this cycle
commit_tag  output  TAG_W  head index
commit_rd  output  5  head rd
commit_regwrite  output  1  head regwrite
commit_value  output  XLEN  head result
commit_pc  output  XLEN  head PC
MisPredict  output  1  retiring entry was mispredicted
redirect_pc  output  XLEN  wb_target of the retiring mispredicted entry; 0 otherwise

Behaviour:
- Storage: per entry, valid, done, mispredict, rd, regwrite, pc, value and target.
- Pointers: head and tail are each TAG_W+1 bits; the extra bit is a wrap bit.
  - Entry index is the low TAG_W bits.
  - count = tail - head, taken modulo 2^(TAG_W+1).
- Status outputs: ROB_full = (count == DEPTH); rob_empty = (count == 0).
  - Both are combinational from registered pointers.
  - alloc_tag = tail[TAG_W-1:0].
- Reset (clk edge with rst_n=0):
  - head, tail and all valid/done/mispredict bits cleared.
  - ROB_full=0, rob_empty=1, alloc_tag=0, all commit_* = 0, MisPredict=0, redirect_pc=0.
  - Reset overrides any alloc, writeback or commit in the same cycle.
  - Reset mid-operation discards all entries.
- Allocate (alloc_valid=1 and ROB_full=0):
  - At the edge, entry[tail] is written with valid=1, done=0, mispredict=0 and the dispatched fields; tail increments.
  - alloc_valid while ROB_full=1 is ignored, even if a commit frees an entry in the same cycle; full is evaluated from pre-edge state.
- Writeback (wb_valid=1):
  - If entry[wb_tag].valid=1, that entry is written at the edge with done=1, value=wb_value, mispredict=wb_mispredict, target=wb_target.
  - Writeback to an invalid entry is ignored.
  - Result becomes visible at the head no earlier than the next cycle; there is no same-cycle bypass to commit.
- Commit (combinational from registered state):
  - commit_valid = entry[head].valid & entry[head].done.
  - When commit_valid=1, commit_* present the head fields; otherwise all commit_* outputs are 0.
  - At most one commit per cycle.
  - On the edge, the head entry's valid is cleared and head increments.
- Misprediction:
  - MisPredict = commit_valid & entry[head].mispredict; redirect_pc = that entry's target.
  - The mispredicted branch itself commits; commit_valid=1 in the same cycle.
  - At that edge, all entries are invalidated and head=tail=0; an alloc in the same cycle is ignored.
  - The next cycle shows rob_empty=1 and MisPredict=0.
- Simultaneous alloc and commit: both take effect, and count is unchanged.
- Wrap-around: pointer indices wrap modulo DEPTH; the wrap bit distinguishes full from empty.
- Timing: latency from writeback to commit is 1 cycle when the entry is at the head. Alloc to earliest commit is 2 cycles (alloc edge, writeback edge, commit cycle).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with alloc_valid=1 -> rob_empty=1, ROB_full=0, alloc_tag=0, commit_valid=0, MisPredict=0.
- Fill: 8 consecutive allocs with no writeback -> alloc_tag goes 0..7, ROB_full=1 after the 8th edge; a 9th alloc_valid leaves tail unchanged and alloc_tag=0.
- Out-of-order writeback: alloc tags 0,1,2; writeback tag 2 (value 0x33), then tag 0 (0x11), then tag 1 (0x22) -> commits in the order tag0/0x11, tag1/0x22, tag2/0x33, one per cycle, and only after tag 1 completes. rob_empty=1 afterwards.
- Wrap and full with commit: fill 8, complete tag 0, then alloc_valid=1 in its commit cycle -> alloc ignored and count=7. Next cycle the alloc is accepted into index 0 with the wrap bit set, and ROB_full=1 again.
- Mispredict: alloc tags 0..3; writeback tag 1 with wb_mispredict=1, wb_target=0x100; writeback tags 0 and 2 -> tag 0 commits, then tag 1 commits with MisPredict=1 and redirect_pc=0x100. Next cycle rob_empty=1, and tag 2 never commits.
- Stale writeback: writeback to an unallocated tag 5 on an empty ROB -> no state change, commit_valid stays 0.
